// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundles the fetch stage's PC-register control, instruction-memory handshake,
// redirect inputs and decode-side buffer outputs.
//   master : the fetch controller (drives PC control, imem request, buffer outputs)
//   slave  : the surrounding pipeline / memory / PC register
interface fetch_ctrl_if;
  logic [31:0] pc_cur;
  logic        pc_write;
  logic        pc_inc;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic        trap;
  logic        id_stall;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  modport master (
    input  pc_cur, imem_ready, imem_rdata, br_taken, br_target, trap, id_stall,
    output pc_write, pc_inc, pc_next, imem_req, imem_addr, inst_valid, inst_out, inst_pc
  );

  modport slave (
    output pc_cur, imem_ready, imem_rdata, br_taken, br_target, trap, id_stall,
    input  pc_write, pc_inc, pc_next, imem_req, imem_addr, inst_valid, inst_out, inst_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer. Requests one instruction at a time from instruction memory,
// holds it in a single-entry buffer toward decode, advances or redirects the PC register and
// discards wrong-path memory responses after a redirect.
// Ports:
//   clk       : clock, all state on rising edge
//   reset     : synchronous active-high reset
//   bus       : fetch_ctrl_if.master (PC control, imem handshake, redirects, decode buffer)
//   perf_fetch/perf_flush : event counters, present only when FETCH_PERF_EN is defined
// Optional feature macro: FETCH_PERF_EN
module fetch_ctrl #(
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               reset,
  fetch_ctrl_if.master       bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch,
  output logic [31:0]        perf_flush
`endif
);

  typedef enum logic [1:0] {StIdle, StFetch, StFull, StDrain} state_e;

  state_e      r_state;
  logic        r_inst_valid;
  logic [31:0] r_inst_out;
  logic [31:0] r_inst_pc;

  logic        w_redirect;
  logic        w_accept;
  logic        w_req;

  // Redirects are ignored in IDLE and while reset is asserted.
  assign w_redirect = !reset && (r_state != StIdle) && (bus.trap || bus.br_taken);
  assign w_req      = !reset && ((r_state == StFetch) || (r_state == StDrain));
  assign w_accept   = !reset && (r_state == StFetch) && bus.imem_ready && !w_redirect;

  always_comb begin
    bus.pc_write = w_redirect;
    bus.pc_inc   = w_accept;
    bus.pc_next  = '0;
    if (w_redirect) begin
      bus.pc_next = bus.trap ? TRAP_VEC : {bus.br_target[31:2], 2'b00};
    end
  end

  assign bus.imem_req   = w_req;
  assign bus.imem_addr  = bus.pc_cur;
  assign bus.inst_valid = r_inst_valid;
  assign bus.inst_out   = r_inst_out;
  assign bus.inst_pc    = r_inst_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_inst_valid <= 1'b0;
      r_inst_out   <= '0;
      r_inst_pc    <= '0;
    end else begin
      unique case (r_state)
        StIdle: r_state <= StFetch;
        StFetch: begin
          if (w_redirect) begin
            // A response arriving in the redirect cycle closes the access; otherwise it is
            // still in flight and must be drained before refetching.
            r_state      <= bus.imem_ready ? StFetch : StDrain;
            r_inst_valid <= 1'b0;
          end else if (bus.imem_ready) begin
            r_inst_out   <= bus.imem_rdata;
            r_inst_pc    <= bus.pc_cur;
            r_inst_valid <= 1'b1;
            r_state      <= StFull;
          end
        end
        StFull: begin
          if (w_redirect || !bus.id_stall) begin
            r_inst_valid <= 1'b0;
            r_state      <= StFetch;
          end
        end
        StDrain: begin
          r_inst_valid <= 1'b0;
          if (!w_redirect && bus.imem_ready) begin
            r_state <= StFetch;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch <= '0;
      perf_flush <= '0;
    end else begin
      if (w_accept)   perf_fetch <= perf_fetch + 32'd1;
      if (w_redirect) perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

endmodule
